// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, and registered
// level / press / release / auto-repeat outputs for one key.
module key_debounce #(
    parameter int DEB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    // state     | meaning
    // IDLE      | key released and stable
    // PRESS_CHK | pressed level seen, waiting for it to stay stable
    // HELD      | press accepted, auto-repeat timer running
    // REL_CHK   | released level seen while held, repeat timer frozen
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    localparam int DCW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
    localparam logic [RCW-1:0] RPT_FIRST = (REPEAT_DELAY > 0) ? RCW'(REPEAT_DELAY - 1) : '0;
    // Reloading to DELAY-PERIOD makes every later pulse land PERIOD cycles apart.
    localparam logic [RCW-1:0] RPT_RELOAD =
        (REPEAT_DELAY > REPEAT_PERIOD) ? RCW'(REPEAT_DELAY - REPEAT_PERIOD) : '0;
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    state_t         state_q, state_d;
    logic [1:0]     sync_q;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           repeat_q, repeat_d;
    logic           p;

    assign p = sync_q[1] ^ REL_LVL;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= {2{REL_LVL}};
            state_q   <= IDLE;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_in};
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        rcnt_d    = rcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = PRESS_CHK;
                    dcnt_d  = '0;
                end
            end
            PRESS_CHK: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!p) begin
                    state_d = REL_CHK;
                    dcnt_d  = '0;
                end else if (REPEAT_DELAY != 0) begin
                    if (rcnt_q == RPT_FIRST) begin
                        repeat_d = 1'b1;
                        rcnt_d   = RPT_RELOAD;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            REL_CHK: begin
                if (p) begin
                    state_d = HELD;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low and an active-high instance checked
// against a run-length / held-time reference model, directed plus random stimulus.
module tb_key_debounce;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk;
    logic       rst;
    logic [1:0] kin;
    logic [1:0] d_lvl, d_prs, d_rel, d_rep;

    int total = 0;
    int bad   = 0;

    key_debounce #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)) u_lo (
        .clk(clk), .rst(rst), .key_in(kin[0]),
        .key_level(d_lvl[0]), .key_press(d_prs[0]), .key_release(d_rel[0]), .key_repeat(d_rep[0])
    );

    key_debounce #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst(rst), .key_in(kin[1]),
        .key_level(d_lvl[1]), .key_press(d_prs[1]), .key_release(d_rel[1]), .key_repeat(d_rep[1])
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: a level change is accepted once the synchronized input
    // has disagreed with the level on DEB+1 consecutive edges; repeats are
    // counted from edges spent held with no pending release.
    logic [1:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_rep;
    int         m_run [2];
    int         m_h   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic p_v, lv, prs_v, rel_v, rep_v;
            int   run_v, h_v;
            p_v   = (i == 0) ? ~m_s2[i] : m_s2[i];
            lv    = m_lvl[i];
            run_v = m_run[i];
            h_v   = m_h[i];
            prs_v = 1'b0;
            rel_v = 1'b0;
            rep_v = 1'b0;
            if (!rst) begin
                m_s1[i]  <= (i == 0);
                m_s2[i]  <= (i == 0);
                m_lvl[i] <= 1'b0;
                m_prs[i] <= 1'b0;
                m_rel[i] <= 1'b0;
                m_rep[i] <= 1'b0;
                m_run[i] <= 0;
                m_h[i]   <= 0;
            end else begin
                if (p_v == lv) begin
                    if (lv && run_v == 0) begin
                        h_v = h_v + 1;
                        if (RD != 0 && h_v >= RD && ((h_v - RD) % RP) == 0) rep_v = 1'b1;
                    end
                    run_v = 0;
                end else begin
                    run_v = run_v + 1;
                    if (run_v == DEB + 1) begin
                        lv    = p_v;
                        run_v = 0;
                        if (p_v) begin
                            prs_v = 1'b1;
                            h_v   = 0;
                        end else begin
                            rel_v = 1'b1;
                        end
                    end
                end
                m_s1[i]  <= kin[i];
                m_s2[i]  <= m_s1[i];
                m_lvl[i] <= lv;
                m_prs[i] <= prs_v;
                m_rel[i] <= rel_v;
                m_rep[i] <= rep_v;
                m_run[i] <= run_v;
                m_h[i]   <= h_v;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        kin = 2'b01;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({d_lvl[i], d_prs[i], d_rel[i], d_rep[i]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset inst=%0d got=%b exp=0000", i, {d_lvl[i], d_prs[i], d_rel[i], d_rep[i]});
            end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean_press();
        kin = 2'b10;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (d_prs[i] !== (k == 7) || d_lvl[i] !== (k >= 7) || d_rep[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL clean_press inst=%0d edge=%0d got lvl=%b prs=%b rep=%b exp lvl=%b prs=%b rep=0",
                             i, k, d_lvl[i], d_prs[i], d_rep[i], (k >= 7), (k == 7));
                end
            end
        end
    endtask

    // Continues the hold from test_clean_press; d counts cycles after key_press.
    task automatic test_repeat();
        for (int d = 3; d <= 39; d++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (d_rep[i] !== (d >= 10 && (d % 5) == 0) || d_prs[i] !== 1'b0 || d_rel[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL repeat inst=%0d d=%0d got rep=%b prs=%b rel=%b exp rep=%b",
                             i, d, d_rep[i], d_prs[i], d_rel[i], (d >= 10 && (d % 5) == 0));
                end
            end
        end
    endtask

    task automatic test_release();
        int reps;
        reps = 0;
        kin = 2'b01;
        repeat (2) @(negedge clk);
        kin = 2'b10;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            reps += int'(d_rep[0]);
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({d_lvl[i], d_prs[i], d_rel[i], d_rep[i]} !== {m_lvl[i], m_prs[i], m_rel[i], m_rep[i]}
                    || d_rel[i] !== 1'b0 || d_lvl[i] !== 1'b1) begin
                    bad++;
                    $display("FAIL release_glitch inst=%0d c=%0d got=%b exp=%b", i, c,
                             {d_lvl[i], d_prs[i], d_rel[i], d_rep[i]}, {m_lvl[i], m_prs[i], m_rel[i], m_rep[i]});
                end
            end
        end
        total++;
        if (reps < 2) begin
            bad++;
            $display("FAIL repeat_after_glitch got=%0d pulses exp>=2", reps);
        end
        kin = 2'b01;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (d_rel[i] !== (k == 7) || d_lvl[i] !== (k < 7) || (k >= 7 && d_rep[i] !== 1'b0)
                    || d_rep[i] !== m_rep[i]) begin
                    bad++;
                    $display("FAIL release inst=%0d edge=%0d got lvl=%b rel=%b rep=%b exp lvl=%b rel=%b rep=%b",
                             i, k, d_lvl[i], d_rel[i], d_rep[i], (k < 7), (k == 7), m_rep[i]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < 6; c++) begin
                kin = (c < 3) ? 2'b10 : 2'b01;
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if ({d_lvl[i], d_prs[i], d_rel[i], d_rep[i]} !== 4'b0000) begin
                        bad++;
                        $display("FAIL bounce inst=%0d n=%0d c=%0d got=%b exp=0000", i, n, c,
                                 {d_lvl[i], d_prs[i], d_rel[i], d_rep[i]});
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        kin = 2'b10;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({d_lvl[i], d_prs[i], d_rel[i], d_rep[i]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_mid_hold inst=%0d got=%b exp=0000", i, {d_lvl[i], d_prs[i], d_rel[i], d_rep[i]});
            end
        end
        rst = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (d_prs[i] !== (k == 7) || d_lvl[i] !== (k >= 7)) begin
                    bad++;
                    $display("FAIL repress_after_reset inst=%0d edge=%0d got lvl=%b prs=%b exp lvl=%b prs=%b",
                             i, k, d_lvl[i], d_prs[i], (k >= 7), (k == 7));
                end
            end
        end
    endtask

    task automatic test_active_high();
        kin = 2'b01;
        repeat (12) @(negedge clk);
        kin = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            total++;
            if (d_prs[1] !== (k == 7) || d_lvl[1] !== (k >= 7) || d_lvl[0] !== 1'b0) begin
                bad++;
                $display("FAIL active_high edge=%0d got lvl=%b prs=%b lo_lvl=%b exp lvl=%b prs=%b lo_lvl=0",
                         k, d_lvl[1], d_prs[1], d_lvl[0], (k >= 7), (k == 7));
            end
        end
        kin = 2'b01;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        int left [2];
        left[0] = 1;
        left[1] = 1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                left[i]--;
                if (left[i] == 0) begin
                    kin[i]  = ~kin[i];
                    left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                                          : int'($urandom_range(1, 6));
                end
            end
            rst = ($urandom_range(0, 199) != 0);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({d_lvl[i], d_prs[i], d_rel[i], d_rep[i]} !== {m_lvl[i], m_prs[i], m_rel[i], m_rep[i]}) begin
                    bad++;
                    $display("FAIL random inst=%0d c=%0d got=%b exp=%b", i, c,
                             {d_lvl[i], d_prs[i], d_rel[i], d_rep[i]}, {m_lvl[i], m_prs[i], m_rel[i], m_rep[i]});
                end
                total++;
                if (int'(d_prs[i]) + int'(d_rel[i]) + int'(d_rep[i]) > 1) begin
                    bad++;
                    $display("FAIL pulse_exclusive inst=%0d c=%0d got prs=%b rel=%b rep=%b exp at most one",
                             i, c, d_prs[i], d_rel[i], d_rep[i]);
                end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        kin = 2'b01;
        test_reset();
        test_clean_press();
        test_repeat();
        test_release();
        test_bounce();
        test_reset_mid_hold();
        test_active_high();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
